// File: rtl/la_wb_initiator.sv
// Wishbone B4 classic single-cycle initiator driven from logic-analyzer bits.
// Issues one read or write per rising edge of cmd_req_i and reports done/error/data back.
module la_wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_req_i,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_done_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic [15:0] txn_count_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_req_q;
  logic [15:0] r_tmo;
  logic [15:0] r_txn_count;
  logic        r_bus;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic [31:0] r_rsp_dat;
  logic        r_done;
  logic        r_err;
  logic        w_start;

  assign w_start = cmd_req_i & ~r_req_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_req_q     <= 1'b0;
      r_tmo       <= '0;
      r_txn_count <= '0;
      r_bus       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_rsp_dat   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // req_q tracks the input in every state so a held request never restarts
      r_req_q <= cmd_req_i;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_BUS;
            r_bus   <= 1'b1;
            r_we    <= cmd_we_i;
            r_adr   <= cmd_adr_i;
            r_dat   <= cmd_dat_i;
            r_sel   <= cmd_sel_i;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_tmo   <= '0;
          end
        end
        S_BUS: begin
          // ack takes priority over a timeout expiring on the same edge
          if (wbm_ack_i) begin
            r_state     <= S_IDLE;
            r_bus       <= 1'b0;
            r_done      <= 1'b1;
            r_err       <= 1'b0;
            r_txn_count <= r_txn_count + 16'd1;
            if (!r_we) r_rsp_dat <= wbm_dat_i;
          end else if (r_tmo == TMO_LAST) begin
            r_state     <= S_IDLE;
            r_bus       <= 1'b0;
            r_done      <= 1'b1;
            r_err       <= 1'b1;
            r_txn_count <= r_txn_count + 16'd1;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
      endcase
    end
  end

  assign wbm_cyc_o   = r_bus;
  assign wbm_stb_o   = r_bus;
  assign busy_o      = r_bus;
  assign wbm_we_o    = r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign wbm_sel_o   = r_sel;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_done_o  = r_done;
  assign rsp_err_o   = r_err;
  assign txn_count_o = r_txn_count;

endmodule

// File: doc/la_wb_initiator.md
# la_wb_initiator

- Wishbone B4 classic initiator, driven from the logic analyzer (LA) bus, that issues single read/write cycles to the user-project Wishbone responder.
- Lets firmware or a testbench reach user-project registers through LA bits, without going through the management Wishbone path.
- Sits inside the user project wrapper between the LA inputs/outputs and the responder's `wbs_*` ports.
- Reports completion, read data and bus timeouts back on LA outputs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles `stb` is held awaiting `ack`. Legal range 1..65535.

Ports:
- `wb_clk_i` in 1: sole clock, rising edge.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `cmd_req_i` in 1: command request; rising edge starts a transaction.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_adr_i` in 32: byte address.
- `cmd_dat_i` in 32: write data.
- `cmd_sel_i` in 4: byte selects.
- `rsp_dat_o` out 32: read data of last completed read.
- `rsp_done_o` out 1: sticky, last command finished.
- `rsp_err_o` out 1: sticky, last command timed out.
- `busy_o` out 1: transaction in progress.
- `txn_count_o` out 16: completed-command counter, wraps.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: Wishbone controls.
- `wbm_adr_o` out 32, `wbm_dat_o` out 32, `wbm_sel_o` out 4: Wishbone address/data/selects.
- `wbm_ack_i` in 1: Wishbone acknowledge.
- `wbm_dat_i` in 32: Wishbone read data.

## Operation
- One registered copy `req_q` of `cmd_req_i`; start condition is `cmd_req_i & ~req_q`, evaluated every cycle.
- FSM states:
  - IDLE → BUS on start: latch `cmd_we/adr/dat/sel` into `wbm_*`, clear `rsp_done_o` and `rsp_err_o`, clear timeout counter.
  - BUS: `wbm_cyc_o = wbm_stb_o = 1`, `busy_o = 1`.
  - BUS → IDLE on `wbm_ack_i`: if read, capture `wbm_dat_i` into `rsp_dat_o`; set `rsp_done_o`; increment `txn_count_o`.
  - BUS → IDLE on timeout: counter equals `TIMEOUT_CYCLES-1` with no `ack`. Set `rsp_done_o` and `rsp_err_o`; `rsp_dat_o` unchanged; `txn_count_o` still increments.
- `ack` and timeout on the same edge: `ack` wins, `rsp_err_o = 0`.
- Start edges seen while in BUS are ignored, not queued. `req_q` still tracks the input, so a request held high across completion does not restart.
- Write data never reaches `rsp_dat_o`.
- `wbm_adr/dat/sel/we` hold their values after completion until the next start.
- `txn_count_o` wraps from 0xFFFF to 0x0000.

## Timing
- Reset values: all `wbm_*` outputs 0, `rsp_dat_o` 0, `rsp_done_o` 0, `rsp_err_o` 0, `busy_o` 0, `txn_count_o` 0, `req_q` 0, FSM in IDLE.
- Asserting `wb_rst_i` mid-transaction drops `cyc`/`stb` immediately (asynchronous) and clears all state. No completion is recorded.
- Start detected at edge N: `cyc`/`stb`/`busy` high after edge N.
- `ack` sampled high at edge M:
  - `cyc`/`stb`/`busy` low after edge M.
  - `rsp_done_o`, `rsp_dat_o` and `txn_count_o` update after edge M.
  - Minimum bus occupancy is 1 cycle (`ack` at N+1).
- Timeout: `stb` held exactly `TIMEOUT_CYCLES` cycles. With `TIMEOUT_CYCLES = 1` and no `ack`, `stb` is high for one cycle.
- Earliest re-start: a new rising edge sampled at edge M+1 gives `stb` again after M+1.
- `wbm_ack_i` is ignored in IDLE.

## Test plan
- **Write:** adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF, we=1, pulse req; responder acks after 3 cycles → `stb` high 3 cycles with those values; `done=1`, `err=0`, `txn_count=1`, `rsp_dat` still 0.
- **Read:** adr=0x3000_0008, we=0; responder acks with 0x1234_5678 on the first `stb` cycle → `stb` high 1 cycle; `rsp_dat=0x12345678`, `done=1`.
- **Timeout:** `TIMEOUT_CYCLES=4`, responder never acks → `stb` high exactly 4 cycles; `done=1`, `err=1`, `rsp_dat` unchanged, `txn_count` incremented.
- **Ack/timeout collision:** `ack` asserted on the 4th cycle with `TIMEOUT_CYCLES=4` → `err=0`, read data captured.
- **Ignored re-request:** second rising edge of req during BUS → no second transaction; exactly one `stb` burst; `txn_count` +1. Holding req high after completion also produces no new transaction.
- **Reset and wrap:**
  - Reset asserted on the 2nd `stb` cycle → `cyc`/`stb` low without waiting for a clock edge; all outputs 0 after release.
  - Preload 0xFFFF completions (force or loop) → next completion gives `txn_count=0x0000`.
